// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with store encode, load extract and writeback select
//
// Sits between the execute-stage ALU and the data memory / writeback path.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, stall, flush      pipeline control (flush > stall > advance)
//   alu_out, rs2_data, funct3   ALU result / effective address, store data, width field
//   is_load, is_store           memory operation type
//   rd, reg_wen, wb_sel         destination register, write enable, writeback source
//   pc_plus4                    link value for jumps
//   dmem_rdata                  same-cycle read data at mem_addr
//   mem_addr, mem_wdata, mem_we registered memory request
//   out_valid, out_rd           registered stage valid and destination
//   out_reg_wen                 registered write enable, gated by misalignment
//   misalign_err                registered misaligned-access flag
//   wb_data                     combinational writeback value
module ex_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [2:0]      funct3,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [4:0]      rd,
    input  logic            reg_wen,
    input  logic [1:0]      wb_sel,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_we,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic            out_reg_wen,
    output logic            misalign_err,
    output logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_we_q, mem_we_d;
    logic            out_valid_q, out_valid_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_reg_wen_q, out_reg_wen_d;
    logic            misalign_err_q, misalign_err_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [1:0]      wb_sel_q, wb_sel_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

    logic            misaligned;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_we;

    // Store encode and misalignment detection on the incoming instruction.
    always_comb begin
        misaligned = in_valid & (is_load | is_store) &
                     (((funct3[1:0] == 2'b01) & alu_out[0]) |
                      ((funct3[1:0] == 2'b10) & (alu_out[1:0] != 2'b00)));
        st_wdata = rs2_data;
        st_we    = 4'b0000;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data[7:0]}};
                st_we    = 4'b0001 << alu_out[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_data[15:0]}};
                st_we    = alu_out[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                st_wdata = rs2_data;
                st_we    = 4'b1111;
            end
            default: begin
                st_wdata = rs2_data;
                st_we    = 4'b0000;
            end
        endcase
        // Only a valid, aligned store may touch memory.
        if (!(in_valid & is_store & !misaligned)) begin
            st_we = 4'b0000;
        end
    end

    // Next-state: flush empties the stage but keeps the data fields.
    always_comb begin
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_we_d       = mem_we_q;
        out_valid_d    = out_valid_q;
        out_rd_d       = out_rd_q;
        out_reg_wen_d  = out_reg_wen_q;
        misalign_err_d = misalign_err_q;
        funct3_d       = funct3_q;
        addr_lo_d      = addr_lo_q;
        wb_sel_d       = wb_sel_q;
        pc_plus4_d     = pc_plus4_q;
        if (flush) begin
            out_valid_d    = 1'b0;
            mem_we_d       = 4'b0000;
            out_reg_wen_d  = 1'b0;
            misalign_err_d = 1'b0;
        end else if (!stall) begin
            mem_addr_d     = alu_out;
            mem_wdata_d    = st_wdata;
            mem_we_d       = st_we;
            out_valid_d    = in_valid;
            out_rd_d       = rd;
            out_reg_wen_d  = in_valid & reg_wen & !misaligned;
            misalign_err_d = misaligned;
            funct3_d       = funct3;
            addr_lo_d      = alu_out[1:0];
            wb_sel_d       = wb_sel;
            pc_plus4_d     = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_we_q       <= 4'b0000;
            out_valid_q    <= 1'b0;
            out_rd_q       <= 5'd0;
            out_reg_wen_q  <= 1'b0;
            misalign_err_q <= 1'b0;
            funct3_q       <= 3'd0;
            addr_lo_q      <= 2'd0;
            wb_sel_q       <= 2'd0;
            pc_plus4_q     <= '0;
        end else begin
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_we_q       <= mem_we_d;
            out_valid_q    <= out_valid_d;
            out_rd_q       <= out_rd_d;
            out_reg_wen_q  <= out_reg_wen_d;
            misalign_err_q <= misalign_err_d;
            funct3_q       <= funct3_d;
            addr_lo_q      <= addr_lo_d;
            wb_sel_q       <= wb_sel_d;
            pc_plus4_q     <= pc_plus4_d;
        end
    end

    // Load extract from the same-cycle memory word.
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            3'b010:  ld_data = dmem_rdata;
            default: ld_data = '0;
        endcase
        case (wb_sel_q)
            2'd0:    wb_data = mem_addr_q;
            2'd1:    wb_data = ld_data;
            2'd2:    wb_data = pc_plus4_q;
            default: wb_data = '0;
        endcase
    end

    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign out_valid    = out_valid_q;
    assign out_rd       = out_rd_q;
    assign out_reg_wen  = out_reg_wen_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard testbench for ex_mem_stage
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, stall, flush, is_load, is_store, reg_wen;
    logic [31:0] alu_out, rs2_data, pc_plus4, dmem_rdata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_we;
    logic        out_valid, out_reg_wen, misalign_err;
    logic [4:0]  out_rd;

    ex_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_out(alu_out), .rs2_data(rs2_data), .funct3(funct3), .is_load(is_load),
        .is_store(is_store), .rd(rd), .reg_wen(reg_wen), .wb_sel(wb_sel),
        .pc_plus4(pc_plus4), .dmem_rdata(dmem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .out_valid(out_valid), .out_rd(out_rd),
        .out_reg_wen(out_reg_wen), .misalign_err(misalign_err), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wd;
        logic [3:0]  we;
        logic        valid;
        logic [4:0]  rd;
        logic        rwen;
        logic        mis;
        logic [31:0] wb;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every cycle the stage presents a result for a pending expectation, compare it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".mem_addr"},     mem_addr,            e.addr);
            if (e.chk_wd) check({e.name, ".mem_wdata"}, mem_wdata, e.wdata);
            check({e.name, ".mem_we"},       {28'd0, mem_we},     {28'd0, e.we});
            check({e.name, ".out_valid"},    {31'd0, out_valid},  {31'd0, e.valid});
            check({e.name, ".out_rd"},       {27'd0, out_rd},     {27'd0, e.rd});
            check({e.name, ".out_reg_wen"},  {31'd0, out_reg_wen},{31'd0, e.rwen});
            check({e.name, ".misalign_err"}, {31'd0, misalign_err},{31'd0, e.mis});
            check({e.name, ".wb_data"},      wb_data,             e.wb);
        end
    end

    // Drive one cycle of stimulus and queue the hand-computed result of that edge.
    task automatic issue(
        input string       nm,
        input logic        v, st, fl,
        input logic [31:0] alu, rs2,
        input logic [2:0]  f3,
        input logic        ld, sto,
        input logic [4:0]  rdi,
        input logic        rw,
        input logic [1:0]  ws,
        input logic [31:0] pc4, rdata,
        input logic [31:0] x_addr, x_wdata,
        input logic        x_chk,
        input logic [3:0]  x_we,
        input logic        x_valid,
        input logic [4:0]  x_rd,
        input logic        x_rwen, x_mis,
        input logic [31:0] x_wb
    );
        exp_t x;
        @(posedge clk);
        #2;
        in_valid = v; stall = st; flush = fl; alu_out = alu; rs2_data = rs2;
        funct3 = f3; is_load = ld; is_store = sto; rd = rdi; reg_wen = rw;
        wb_sel = ws; pc_plus4 = pc4; dmem_rdata = rdata;
        x.name = nm; x.addr = x_addr; x.wdata = x_wdata; x.chk_wd = x_chk; x.we = x_we;
        x.valid = x_valid; x.rd = x_rd; x.rwen = x_rwen; x.mis = x_mis; x.wb = x_wb;
        sb.push_back(x);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; stall = 0; flush = 0; alu_out = 0; rs2_data = 0; funct3 = 0;
        is_load = 0; is_store = 0; rd = 0; reg_wen = 0; wb_sel = 0; pc_plus4 = 0;
        dmem_rdata = 32'hFFFF_FFFF;
        #12;
        check("rst.mem_addr",  mem_addr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.mem_we",    {28'd0, mem_we}, 32'd0);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out_rd",    {27'd0, out_rd}, 32'd0);
        check("rst.reg_wen",   {31'd0, out_reg_wen}, 32'd0);
        check("rst.misalign",  {31'd0, misalign_err}, 32'd0);
        check("rst.wb_data",   wb_data, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        //    name    v st fl alu           rs2           f3      ld st rd rw ws pc4     rdata          addr          wdata         chk we       vl rd rw mis wb
        issue("sb",    1,0,0, 32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0,1, 0, 0, 0, 32'h0, 32'h0,         32'h0000_1003, 32'hDDDD_DDDD, 1, 4'b1000, 1, 0, 0, 0, 32'h0000_1003);
        issue("sh_mis",1,0,0, 32'h0000_2001, 32'h1122_3344, 3'b001, 0,1, 0, 1, 0, 32'h0, 32'h0,         32'h0000_2001, 32'h0,         0, 4'b0000, 1, 0, 0, 1, 32'h0000_2001);
        issue("sw",    1,0,0, 32'h0000_2004, 32'hCAFE_F00D, 3'b010, 0,1, 0, 0, 0, 32'h0, 32'h0,         32'h0000_2004, 32'hCAFE_F00D, 1, 4'b1111, 1, 0, 0, 0, 32'h0000_2004);
        issue("sh_hi", 1,0,0, 32'h0000_2002, 32'h0000_BEEF, 3'b001, 0,1, 0, 0, 0, 32'h0, 32'h0,         32'h0000_2002, 32'hBEEF_BEEF, 1, 4'b1100, 1, 0, 0, 0, 32'h0000_2002);
        issue("lb",    1,0,0, 32'h0000_3002, 32'h0,         3'b000, 1,0, 5, 1, 1, 32'h0, 32'h12F4_5678, 32'h0000_3002, 32'h0,         0, 4'b0000, 1, 5, 1, 0, 32'hFFFF_FFF4);
        issue("lbu",   1,0,0, 32'h0000_3002, 32'h0,         3'b100, 1,0, 5, 1, 1, 32'h0, 32'h12F4_5678, 32'h0000_3002, 32'h0,         0, 4'b0000, 1, 5, 1, 0, 32'h0000_00F4);
        issue("lhu",   1,0,0, 32'h0000_3002, 32'h0,         3'b101, 1,0, 5, 1, 1, 32'h0, 32'h12F4_5678, 32'h0000_3002, 32'h0,         0, 4'b0000, 1, 5, 1, 0, 32'h0000_12F4);
        issue("lh",    1,0,0, 32'h0000_3002, 32'h0,         3'b001, 1,0, 5, 1, 1, 32'h0, 32'h12F4_5678, 32'h0000_3002, 32'h0,         0, 4'b0000, 1, 5, 1, 0, 32'h0000_12F4);
        issue("lh_neg",1,0,0, 32'h0000_9000, 32'h0,         3'b001, 1,0, 6, 1, 1, 32'h0, 32'h0000_8001, 32'h0000_9000, 32'h0,         0, 4'b0000, 1, 6, 1, 0, 32'hFFFF_8001);
        issue("lw",    1,0,0, 32'h0000_3000, 32'h0,         3'b010, 1,0, 7, 1, 1, 32'h0, 32'h8765_4321, 32'h0000_3000, 32'h0,         0, 4'b0000, 1, 7, 1, 0, 32'h8765_4321);
        issue("lw_mis",1,0,0, 32'h0000_3001, 32'h0,         3'b010, 1,0, 7, 1, 1, 32'h0, 32'h0BAD_F00D, 32'h0000_3001, 32'h0,         0, 4'b0000, 1, 7, 0, 1, 32'h0BAD_F00D);
        issue("jal",   1,0,0, 32'h0000_0200, 32'h0,         3'b000, 0,0, 1, 1, 2, 32'h108, 32'h0,      32'h0000_0200, 32'h0,         0, 4'b0000, 1, 1, 1, 0, 32'h0000_0108);
        issue("sw2",   1,0,0, 32'h0000_4000, 32'h0102_0304, 3'b010, 0,1, 0, 0, 0, 32'h0, 32'h0,         32'h0000_4000, 32'h0102_0304, 1, 4'b1111, 1, 0, 0, 0, 32'h0000_4000);
        issue("stall1",1,1,0, 32'h0000_5555, 32'hFFFF_FFFF, 3'b000, 1,0, 9, 1, 1, 32'h44, 32'h1111_1111, 32'h0000_4000, 32'h0102_0304, 1, 4'b1111, 1, 0, 0, 0, 32'h0000_4000);
        issue("stall2",0,1,0, 32'h0000_6663, 32'h1234_5678, 3'b001, 0,1, 3, 1, 2, 32'h88, 32'h2222_2222, 32'h0000_4000, 32'h0102_0304, 1, 4'b1111, 1, 0, 0, 0, 32'h0000_4000);
        issue("stall3",1,1,0, 32'h0000_7777, 32'h0,         3'b010, 1,0, 4, 1, 3, 32'hCC, 32'h3333_3333, 32'h0000_4000, 32'h0102_0304, 1, 4'b1111, 1, 0, 0, 0, 32'h0000_4000);
        issue("st_fl", 1,1,1, 32'h0000_8888, 32'h0,         3'b010, 0,1, 8, 1, 2, 32'hDD, 32'h0,        32'h0000_4000, 32'h0102_0304, 1, 4'b0000, 0, 0, 0, 0, 32'h0000_4000);
        issue("noval", 0,0,0, 32'h0000_6000, 32'h5555_5555, 3'b010, 0,1, 2, 1, 3, 32'h0, 32'h0,         32'h0000_6000, 32'h0,         0, 4'b0000, 0, 2, 0, 0, 32'h0000_0000);
        issue("sh_m2", 1,0,0, 32'h0000_7001, 32'h0,         3'b001, 0,1, 0, 0, 0, 32'h0, 32'h0,         32'h0000_7001, 32'h0,         0, 4'b0000, 1, 0, 0, 1, 32'h0000_7001);
        issue("fl_nv", 0,0,1, 32'h0000_9999, 32'h0,         3'b000, 0,0, 3, 1, 2, 32'h0, 32'h0,         32'h0000_7001, 32'h0,         0, 4'b0000, 0, 0, 0, 0, 32'h0000_7001);
        issue("st_ill",1,0,0, 32'h0000_8000, 32'hABCD_EF01, 3'b011, 0,1, 0, 0, 3, 32'h0, 32'h0,         32'h0000_8000, 32'h0,         0, 4'b0000, 1, 0, 0, 0, 32'h0000_0000);
        issue("sw_rst",1,0,0, 32'h0000_A000, 32'hDEAD_BEEF, 3'b010, 0,1, 0, 0, 0, 32'h0, 32'h0,         32'h0000_A000, 32'hDEAD_BEEF, 1, 4'b1111, 1, 0, 0, 0, 32'h0000_A000);

        // Hold the store in place, then pulse reset between edges.
        @(posedge clk);
        #2;
        stall = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #3;
        check("held.mem_we", {28'd0, mem_we}, 32'h0000_000F);
        rst_n = 1'b0;
        #1;
        check("arst.mem_we",    {28'd0, mem_we}, 32'd0);
        check("arst.out_valid", {31'd0, out_valid}, 32'd0);
        check("arst.mem_addr",  mem_addr, 32'd0);
        check("arst.wb_data",   wb_data, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
